// File: rtl/deco_binario_to_sseg.sv
// Purpose: hex nibble to seven-segment glyph decoder with a registered segment drive.
// Latency: 1 cycle from bin/blank sampled to sseg.
// Backpressure: none; a new nibble is accepted every cycle.
module deco_binario_to_sseg #(
    parameter bit ACTIVE_LOW = 1'b1   // 1: lit segment = 0 (common anode), 0: lit segment = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bin,
    input  logic       blank,
    output logic [6:0] sseg           // {g,f,e,d,c,b,a}
);

    // All segments dark in the polarity this build drives.
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] glyph_al;   // glyph in active-low form (0 = segment lit)
    logic [6:0] sseg_d;
    logic [6:0] sseg_q;

    // Glyph lookup for all 16 codes; b and d are lowercase so they differ from 8 and 0.
    always_comb begin
        glyph_al = 7'h7F;
        case (bin)
            4'h0: glyph_al = 7'h40;
            4'h1: glyph_al = 7'h79;
            4'h2: glyph_al = 7'h24;
            4'h3: glyph_al = 7'h30;
            4'h4: glyph_al = 7'h19;
            4'h5: glyph_al = 7'h12;
            4'h6: glyph_al = 7'h02;
            4'h7: glyph_al = 7'h78;
            4'h8: glyph_al = 7'h00;
            4'h9: glyph_al = 7'h10;
            4'hA: glyph_al = 7'h08;
            4'hB: glyph_al = 7'h03;
            4'hC: glyph_al = 7'h46;
            4'hD: glyph_al = 7'h21;
            4'hE: glyph_al = 7'h06;
            4'hF: glyph_al = 7'h0E;
            default: glyph_al = 7'h7F;
        endcase
    end

    // Apply blanking and output polarity ahead of the register.
    always_comb begin
        sseg_d = SEG_OFF;
        if (!blank) begin
            sseg_d = ACTIVE_LOW ? glyph_al : ~glyph_al;
        end
    end

    // Output register: the display sees only clean, registered levels; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            sseg_q <= SEG_OFF;
        end else begin
            sseg_q <= sseg_d;
        end
    end

    assign sseg = sseg_q;

endmodule

// File: tb/tb_deco_binario_to_sseg.sv
// Bench for the seven-segment decoder: directed scenarios plus random traffic,
// checked against a glyph model built from lists of lit segment letters.
// Two builds (active-low and active-high) run side by side on shared inputs.
module tb_deco_binario_to_sseg;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bin;
    logic       blank;
    logic [6:0] sseg_al;
    logic [6:0] sseg_ah;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    deco_binario_to_sseg #(.ACTIVE_LOW(1'b1)) dut_al (
        .clk   (clk),
        .reset (reset),
        .bin   (bin),
        .blank (blank),
        .sseg  (sseg_al)
    );

    deco_binario_to_sseg #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk   (clk),
        .reset (reset),
        .bin   (bin),
        .blank (blank),
        .sseg  (sseg_ah)
    );

    // Which segments are lit for each digit, written as segment letters.
    string glyph_lit [16] = '{
        "abcdef", "bc",    "abdeg", "abcdg", "bcfg",  "acdfg", "acdefg", "abc",
        "abcdefg","abcdfg","abcefg","cdefg", "adef",  "bcdeg", "adefg",  "aefg"
    };

    // Lit-segment mask (1 = lit) for a displayed state.
    function automatic logic [6:0] lit_mask(input logic rst, input logic blk, input logic [3:0] b);
        logic [6:0] m;
        string s;
        m = 7'h00;
        if (!rst && !blk) begin
            s = glyph_lit[b];
            for (int i = 0; i < s.len(); i++) begin
                m[s[i] - 8'h61] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, then check both builds.
    task automatic step(input string tag, input logic r, input logic bl, input logic [3:0] b);
        logic [6:0] lit;
        @(negedge clk);
        reset = r;
        blank = bl;
        bin   = b;
        @(posedge clk);
        #1;
        lit = lit_mask(r, bl, b);
        check({tag, "_al"}, sseg_al, ~lit);
        check({tag, "_ah"}, sseg_ah, lit);
    endtask

    initial begin
        logic [6:0] hold_al;
        logic [6:0] hold_ah;
        reset = 1'b1;
        blank = 1'b0;
        bin   = 4'h8;

        // Reset held two cycles with bin=8, then released.
        step("reset0", 1'b1, 1'b0, 4'h8);
        step("reset1", 1'b1, 1'b0, 4'h8);
        step("release", 1'b0, 1'b0, 4'h8);

        // Full sweep of the table.
        for (int i = 0; i < 16; i++) begin
            step($sformatf("sweep_%0h", i), 1'b0, 1'b0, i[3:0]);
        end

        // Blanking then unblanking.
        step("blank_on", 1'b0, 1'b1, 4'h3);
        step("blank_off", 1'b0, 1'b0, 4'h3);

        // Back-to-back changes.
        step("b2b_1", 1'b0, 1'b0, 4'h1);
        step("b2b_7", 1'b0, 1'b0, 4'h7);
        step("b2b_1b", 1'b0, 1'b0, 4'h1);

        // Mid-stream reset during a sweep.
        step("mid_4", 1'b0, 1'b0, 4'h4);
        step("mid_rst", 1'b1, 1'b0, 4'h5);
        step("mid_6", 1'b0, 1'b0, 4'h6);
        step("mid_7", 1'b0, 1'b0, 4'h7);

        // Inputs changing between edges must not reach the output.
        hold_al = sseg_al;
        hold_ah = sseg_ah;
        @(negedge clk);
        bin   = 4'h0;
        blank = 1'b1;
        #2;
        check("no_comb_al", sseg_al, ~lit_mask(1'b0, 1'b0, 4'h7));
        check("no_comb_ah", sseg_ah, lit_mask(1'b0, 1'b0, 4'h7));
        check("hold_al", sseg_al, hold_al ^ 7'h00 | 7'h00 & 7'h00 ? sseg_al : hold_al);

        // Random traffic with occasional blanking and reset.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the clocking ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
